// File: rtl/edge_capture_pkg.sv
// rtl/edge_capture_pkg.sv - shared types and helpers for edge_event_capture
// Purpose: FSM state enum and channel-index width helper used by the
//          capture top level and its testbench.
package edge_capture_pkg;

  typedef enum logic {
    EC_IDLE = 1'b0,
    EC_HOLD = 1'b1
  } ec_state_e;

  // Index width for a channel count, never narrower than one bit.
  function automatic int ec_ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - per-channel synchroniser, history flop and edge pulse
// Purpose: brings one asynchronous event line into clk_50 and emits a
//          one-cycle registered pulse per detected edge.
// Ports:
//   clk_50   in  clock, rising edge
//   reset    in  synchronous, active-high
//   event_i  in  asynchronous event line
//   edge_o   out registered one-cycle edge pulse
// Config: EDGE_CAPTURE_BOTH_EDGES_EN selects rising+falling detection.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_50,
  input  logic reset,
  input  logic event_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [SYNC_STAGES:0]   prime_q;
  logic                   edge_q;
  logic                   edge_d;

  // The reset contents of the chain and history are not real line levels;
  // prime_q[SYNC_STAGES] rises once the history flop holds a sampled level,
  // so a line already high at reset release does not count as an edge.
  always_comb begin
`ifdef EDGE_CAPTURE_BOTH_EDGES_EN
    edge_d = (sync_q[SYNC_STAGES-1] ^ hist_q) & prime_q[SYNC_STAGES];
`else
    edge_d = sync_q[SYNC_STAGES-1] & ~hist_q & prime_q[SYNC_STAGES];
`endif
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      prime_q <= '0;
      edge_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], event_i};
      hist_q  <= sync_q[SYNC_STAGES-1];
      prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
      edge_q  <= edge_d;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/edge_event_capture.sv
// rtl/edge_event_capture.sv - multi-channel edge capture with round-robin reporting
// Purpose: per-channel toggles and saturating edge counters, reported one
//          channel at a time over a registered valid/ready port.
// Ports:
//   clk_50       in  clock, rising edge
//   reset        in  synchronous, active-high
//   event_in     in  [CHANNELS] asynchronous event lines
//   toggle_out   out [CHANNELS] flips once per captured edge
//   evt_valid    out report presented
//   evt_ready    in  consumer accepts report
//   evt_channel  out reporting channel index
//   evt_count    out edges accumulated on that channel
//   evt_overflow out channel counter saturated since its last report
// Config: EDGE_CAPTURE_BOTH_EDGES_EN (in edge_sync) counts both edges.
module edge_event_capture
  import edge_capture_pkg::*;
#(
  parameter  int CHANNELS    = 4,
  parameter  int SYNC_STAGES = 2,
  parameter  int COUNT_WIDTH = 4,
  localparam int CH_W        = ec_ch_width(CHANNELS)
) (
  input  logic                   clk_50,
  input  logic                   reset,
  input  logic [CHANNELS-1:0]    event_in,
  output logic [CHANNELS-1:0]    toggle_out,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [CH_W-1:0]        evt_channel,
  output logic [COUNT_WIDTH-1:0] evt_count,
  output logic                   evt_overflow
);

  ec_state_e              state_q, state_d;
  logic [CHANNELS-1:0]    edge_w;
  logic [CHANNELS-1:0]    toggle_q, toggle_d;
  logic [CHANNELS-1:0]    ovf_q, ovf_d;
  logic [COUNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [COUNT_WIDTH-1:0] cnt_d [CHANNELS];
  logic [CH_W-1:0]        ptr_q, ptr_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   eovf_q, eovf_d;
  logic                   valid_q, valid_d;
  logic [CH_W-1:0]        pick;
  logic                   found;
  logic                   ack;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_50 (clk_50),
      .reset  (reset),
      .event_i(event_in[g]),
      .edge_o (edge_w[g])
    );
  end

  assign ack = (state_q == EC_HOLD) && evt_ready;

  // Round-robin search: walk offsets downward so the smallest offset from
  // the pointer is the last (winning) assignment.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % CHANNELS;
      if (cnt_q[idx] != '0) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
  end

  // Counter update: on acknowledge the reported amount is removed first,
  // then any edge of this cycle is added so nothing arriving in HOLD is lost.
  always_comb begin
    logic [COUNT_WIDTH-1:0] base;
    logic                   of;
    base     = '0;
    of       = 1'b0;
    toggle_d = toggle_q ^ edge_w;
    ovf_d    = ovf_q;
    for (int i = 0; i < CHANNELS; i++) begin
      base = cnt_q[i];
      of   = ovf_q[i];
      if (ack && (ch_q == CH_W'(i))) begin
        base = cnt_q[i] - count_q;
        of   = 1'b0;
      end
      if (edge_w[i]) begin
        if (&base) of = 1'b1;
        else       base = base + COUNT_WIDTH'(1);
      end
      cnt_d[i] = base;
      ovf_d[i] = of;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ch_d    = ch_q;
    count_d = count_q;
    eovf_d  = eovf_q;
    ptr_d   = ptr_q;
    case (state_q)
      EC_IDLE: begin
        if (found) begin
          ch_d    = pick;
          count_d = cnt_q[pick];
          eovf_d  = ovf_q[pick];
          valid_d = 1'b1;
          state_d = EC_HOLD;
        end
      end
      EC_HOLD: begin
        if (evt_ready) begin
          valid_d = 1'b0;
          ptr_d   = (ch_q == CH_W'(CHANNELS - 1)) ? '0 : ch_q + CH_W'(1);
          state_d = EC_IDLE;
        end
      end
      default: state_d = EC_IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q  <= EC_IDLE;
      toggle_q <= '0;
      ovf_q    <= '0;
      ptr_q    <= '0;
      ch_q     <= '0;
      count_q  <= '0;
      eovf_q   <= 1'b0;
      valid_q  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      toggle_q <= toggle_d;
      ovf_q    <= ovf_d;
      ptr_q    <= ptr_d;
      ch_q     <= ch_d;
      count_q  <= count_d;
      eovf_q   <= eovf_d;
      valid_q  <= valid_d;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign toggle_out   = toggle_q;
  assign evt_valid    = valid_q;
  assign evt_channel  = ch_q;
  assign evt_count    = count_q;
  assign evt_overflow = eovf_q;

endmodule
